// File: rtl/rf_scan.sv
// rf_scan: debug read-out sequencer for the register file debug port.
// Drives ra0 and reads rd0, which is combinationally valid for the registered
// ra0. Register contents are streamed to a sink over a valid/ready handshake.
// The block can sweep x0..x(NREG-1) or read a single register.
// Optional build macro: RF_SCAN_SKIP_ZERO_EN. When it is defined, registers
// that read as zero produce no beat, and each skipped register costs one cycle.
module rf_scan #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          single,
    input  logic [AW-1:0] sel_addr,
    output logic [AW-1:0] ra0,
    input  logic [DW-1:0] rd0,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [AW-1:0] ra0_r;
    logic [AW-1:0] ra0_s;
    logic          single_r;
    logic          single_s;
    logic          out_valid_r;
    logic          out_valid_s;
    logic [AW-1:0] out_addr_r;
    logic [AW-1:0] out_addr_s;
    logic [DW-1:0] out_data_r;
    logic [DW-1:0] out_data_s;
    logic          busy_r;
    logic          done_r;
    logic          last_s;

    // The sweep ends on the final index or after a single-register read.
    assign last_s = single_r || (ra0_r == LAST_ADDR);

    // Next-state and next-value logic for the sequencer.
    always_comb begin
        state_s     = state_r;
        ra0_s       = ra0_r;
        single_s    = single_r;
        out_valid_s = out_valid_r;
        out_addr_s  = out_addr_r;
        out_data_s  = out_data_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    ra0_s    = single ? sel_addr : {AW{1'b0}};
                    single_s = single;
                    state_s  = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
`ifdef RF_SCAN_SKIP_ZERO_EN
                if (rd0 == {DW{1'b0}}) begin
                    // A zero register produces no beat.
                    if (last_s) begin
                        state_s = DONE;
                    end else begin
                        ra0_s   = ra0_r + AW'(1);
                        state_s = READ;
                    end
                end else begin
                    out_data_s  = rd0;
                    out_addr_s  = ra0_r;
                    out_valid_s = 1'b1;
                    state_s     = SEND;
                end
`else
                out_data_s  = rd0;
                out_addr_s  = ra0_r;
                out_valid_s = 1'b1;
                state_s     = SEND;
`endif
            end
            SEND: begin
                if (out_valid_r && out_ready) begin
                    out_valid_s = 1'b0;
                    if (last_s) begin
                        state_s = DONE;
                    end else begin
                        ra0_s   = ra0_r + AW'(1);
                        state_s = READ;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; busy and done are computed from the next state
    // so that both are registered and line up with the state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            ra0_r       <= {AW{1'b0}};
            single_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_addr_r  <= {AW{1'b0}};
            out_data_r  <= {DW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ra0_r       <= ra0_s;
            single_r    <= single_s;
            out_valid_r <= out_valid_s;
            out_addr_r  <= out_addr_s;
            out_data_r  <= out_data_s;
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == DONE);
        end
    end

    assign ra0       = ra0_r;
    assign out_valid = out_valid_r;
    assign out_addr  = out_addr_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_rf_scan.sv
// tb_rf_scan: directed self-checking bench for rf_scan with a small
// register-file model on the debug read port.
module tb_rf_scan;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        single = 1'b0;
    logic [4:0]  sel_addr = 5'd0;
    logic [4:0]  ra0;
    logic [31:0] rd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];
    logic [31:0] snap [32];
    logic [4:0]  b_addr [64];
    logic [31:0] b_data [64];
    int          nb;
    int          done_cyc;
    int          n_done;
    int          first_cyc;
    int          n_cmp = 0;
    int          n_bad = 0;

    rf_scan #(.NREG(32), .AW(5), .DW(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .single(single),
        .sel_addr(sel_addr), .ra0(ra0), .rd0(rd0), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Register file debug port: x0 reads 0, x2 reads 32'h2ffc.
    assign rd0 = (ra0 == 5'd0) ? 32'd0 : (ra0 == 5'd2) ? 32'h2ffc : rf[ra0];

    function automatic logic [31:0] rfv(input int k);
        if (k == 0) return 32'd0;
        if (k == 2) return 32'h2ffc;
        return rf[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation: start at a negedge, then collect beats and done timing.
    // The cycle count is the number of posedges after start was driven.
    task automatic run(input logic sgl, input logic [4:0] sa, input int stall_at,
                       input int stall_len, input int race_at, input int busy_start);
        int  stalled;
        bit  fin;
        for (int k = 0; k < 32; k++) snap[k] = rfv(k);
        nb = 0; n_done = 0; done_cyc = -1; first_cyc = -1; stalled = 0; fin = 0;
        @(negedge clk);
        start = 1'b1; single = sgl; sel_addr = sa; out_ready = 1'b1;
        for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
            @(negedge clk);
            start = (busy_start != 0) && (cyc == busy_start);
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("done_one_cycle", {31'd0, done}, 32'd0);
                chk("idle_after_done", {31'd0, busy}, 32'd0);
                fin = 1;
            end
            if (out_valid && nb == stall_at && stalled < stall_len) begin
                if (race_at == stall_at && stalled == 0) rf[race_at] = 32'hDEAD_BEEF;
                chk("stall_addr", {27'd0, out_addr}, stall_at);
                chk("stall_data", out_data, snap[stall_at]);
                stalled++;
                out_ready = 1'b0;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready && nb < 64) begin
                b_addr[nb] = out_addr;
                b_data[nb] = out_data;
                nb++;
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
        start = 1'b0;
    endtask

    task automatic check_sweep(input int exp_done);
        chk("beat_count", nb, 32'd32);
        for (int k = 0; k < 32 && k < nb; k++) begin
            chk("beat_addr", {27'd0, b_addr[k]}, k);
            chk("beat_data", b_data[k], snap[k]);
        end
        chk("first_latency", first_cyc, 32'd2);
        chk("done_cycle", done_cyc, exp_done);
        chk("done_count", n_done, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ra0"}, {27'd0, ra0}, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_addr"}, {27'd0, out_addr}, 32'd0);
        chk({tag, "_data"}, out_data, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        bit found;
        for (int k = 0; k < 32; k++) rf[k] = k * 16;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;

`ifdef RF_SCAN_SKIP_ZERO_EN
        for (int k = 0; k < 32; k++) rf[k] = 32'd0;
        rf[4] = 32'd7;
        run(1'b0, 5'd0, -1, 0, -1, 0);
        chk("skip_count", nb, 32'd2);
        chk("skip_b0_addr", {27'd0, b_addr[0]}, 32'd2);
        chk("skip_b0_data", b_data[0], 32'h2ffc);
        chk("skip_b1_addr", {27'd0, b_addr[1]}, 32'd4);
        chk("skip_b1_data", b_data[1], 32'd7);
        chk("skip_done", n_done, 32'd1);
        run(1'b1, 5'd0, -1, 0, -1, 0);
        chk("skip_single_zero_beats", nb, 32'd0);
        chk("skip_single_zero_done", n_done, 32'd1);
`else
        // Full sweep, no backpressure.
        run(1'b0, 5'd0, -1, 0, -1, 0);
        check_sweep(65);
        chk("sweep_b0", b_data[0], 32'd0);
        chk("sweep_b2", b_data[2], 32'h2ffc);
        chk("sweep_b5", b_data[5], 32'h50);

        // Backpressure for 5 cycles on beat 7.
        run(1'b0, 5'd0, 7, 5, -1, 0);
        check_sweep(70);

        // Single read of x2, with a start pulse while busy.
        run(1'b1, 5'd2, -1, 0, -1, 1);
        chk("single_count", nb, 32'd1);
        chk("single_addr", {27'd0, b_addr[0]}, 32'd2);
        chk("single_data", b_data[0], 32'h2ffc);
        chk("single_done", done_cyc, 32'd3);
        repeat (5) @(negedge clk);
        chk("no_queued_start_valid", {31'd0, out_valid}, 32'd0);
        chk("no_queued_start_busy", {31'd0, busy}, 32'd0);

        // Single read of the last register.
        run(1'b1, 5'd31, -1, 0, -1, 0);
        chk("single31_count", nb, 32'd1);
        chk("single31_addr", {27'd0, b_addr[0]}, 32'd31);
        chk("single31_data", b_data[0], 32'h1f0);
        chk("single31_done", done_cyc, 32'd3);

        // Write to x9 while beat 9 is pending.
        run(1'b0, 5'd0, 9, 2, 9, 0);
        check_sweep(67);
        chk("race_old_value", b_data[9], 32'h90);
        run(1'b0, 5'd0, -1, 0, -1, 0);
        check_sweep(65);
        chk("race_new_value", b_data[9], 32'hDEAD_BEEF);

        // Reset in the middle of a sweep.
        @(negedge clk);
        start = 1'b1; single = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (out_valid && out_addr == 5'd12) found = 1;
            else @(negedge clk);
        end
        chk("reach_beat12", {31'd0, found}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        chk("midreset_no_done", {31'd0, done}, 32'd0);
        rstn = 1'b1;
        run(1'b0, 5'd0, -1, 0, -1, 0);
        check_sweep(65);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
